fp_addsub_pipe: RTL and testbench
=================================

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent field width, bias 2^(EXP_W-1)-1.
REQ-002 SHALL have parameter MAN_W, default 15: stored mantissa width, hidden leading one.
REQ-003 SHALL derive WIDTH = 1+EXP_W+MAN_W (24 by default); operand layout {sign, exponent, mantissa}.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port valid_i  input  1  input operands and op are valid this cycle.
REQ-007 SHALL have port ready_o  output  1  block accepts input this cycle.
REQ-008 SHALL have port op_i  input  2  00 add/sub by sign, 01 max, 10 min, 11 reserved.
REQ-009 SHALL have port a_i, b_i  input  WIDTH  operands.
REQ-010 SHALL have port valid_o  output  1  result_o/flags_o valid.
REQ-011 SHALL have port ready_i  input  1  downstream accepts result.
REQ-012 SHALL have port result_o  output  WIDTH  result.
REQ-013 SHALL have port flags_o  output  2  {overflow, zero}.

Function
REQ-014 SHALL transfer input when valid_i && ready_o, and output when valid_o && ready_i.
REQ-015 SHALL be a 3-stage pipeline: S1 unpack/compare/align, S2 mantissa add/subtract, S3 normalise/pack/flags.
REQ-016 SHALL deliver results in order with latency 3 cycles (accept edge to valid_o) when ready_i is held high.
REQ-017 SHALL drive ready_o = !valid_S3 || ready_i; when low, all three stages hold contents unchanged.
REQ-018 SHALL accept one transfer per cycle at full throughput while ready_i is high; bubbles propagate as invalid stages.
REQ-019 SHALL hold result_o/flags_o stable while valid_o && !ready_i.
REQ-020 SHALL treat exponent field 0 as zero (flush-to-zero input), regardless of mantissa bits.
REQ-021 SHALL, for op 00, select the larger-magnitude operand as max (a_i on tie), shift the smaller's {1,mantissa} right by the exponent difference, truncate shifted-out bits.
REQ-022 SHALL, if exponent difference > MAN_W+1, return the larger-magnitude operand unchanged.
REQ-023 SHALL add magnitudes when signs equal; on carry, shift right 1 and increment exponent.
REQ-024 SHALL subtract magnitudes when signs differ, with result sign = larger-magnitude operand's sign.
REQ-025 SHALL normalise via leading-one detect over MAN_W+1 bits; shift left, decrement exponent.
REQ-026 SHALL output +0 (all zeros), zero flag set, when the subtraction result mantissa is zero.
REQ-027 SHALL flush to +0 with the zero flag set when the normalised exponent is <= 0.
REQ-028 SHALL output signed infinity {sign, all-ones, 0} with the overflow flag set when the exponent reaches 2^EXP_W-1.
REQ-029 SHALL, for ops 01/10, compare as signed values (sign first, then magnitude), return a_i on equality, and clear flags except zero when exponent is 0.
REQ-030 SHALL output result 0 with flags 00 for op 11.

Reset
REQ-031 SHALL clear all stage valid bits on rst_i; valid_o=0, result_o=0, flags_o=0 the cycle after.
REQ-032 SHALL discard in-flight operations on reset mid-pipeline; none appear after reset deasserts.
REQ-033 SHALL drive ready_o=1 during and after reset.

Verification
REQ-034 SHALL pass: add 0x3F8000+0x3F8000 (1.0+1.0) -> 0x400000 at cycle 3, flags 00; 0x400000+0x3F8000 -> 0x404000.
REQ-035 SHALL pass: add 0x400000 + 0xBF8000 (2.0+-1.0) -> 0x3F8000; 0x3F8000 + 0xBF8000 -> 0x000000, flags 01.
REQ-036 SHALL pass: add 0x7F7FFF+0x7F7FFF -> 0x7F8000, flags 10; max(0xC00000,0x3F8000) -> 0x3F8000; min -> 0xC00000.
REQ-037 SHALL pass: 4 back-to-back inputs with ready_i low for cycles 2-5 -> ready_o low while S3 full; all 4 results in order, none lost or duplicated.
REQ-038 SHALL pass: rst_i pulsed with 3 ops in flight -> valid_o 0 next cycle, no stale result afterward; next op has latency 3.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage floating-point add/sub, max and min with
// valid/ready handshaking on both sides. Exponent 0 is treated as zero.
// S1 unpacks, compares and aligns; S2 adds or subtracts the mantissas;
// S3 normalises, packs and raises the {overflow, zero} flags.
module fp_addsub_pipe #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 15,
  localparam int WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [1:0]       flags_o
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MAX = 2'b01,
    OP_MIN = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  localparam int               SIG_W   = MAN_W + 1;
  localparam logic [EXP_W-1:0] MAX_SH  = EXP_W'(MAN_W + 1);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  // Pipeline-wide advance: every stage moves together or holds together.
  logic adv;
  logic v1, v2, v3;

  assign adv     = !v3 || ready_i;
  assign ready_o = rst_i || adv;

  // ---------------- S1: unpack, compare, align ----------------
  op_e              op_s;
  logic             a_zero, b_zero, a_big, a_ge, a_eq, sub_n;
  logic [WIDTH-2:0] mag_a, mag_b;
  logic [WIDTH-1:0] big, sel_max, sel_min;
  logic [EXP_W-1:0] big_e, sml_e, diff;
  logic [MAN_W-1:0] sml_man;
  logic [SIG_W-1:0] big_sig, sml_sig;
  logic             byp_n;
  logic [WIDTH-1:0] byp_res_n;
  logic [1:0]       byp_fl_n;

  // Magnitude ordering, alignment, and the max/min/reserved results
  // (which skip the arithmetic stages entirely).
  always_comb begin
    op_s    = op_e'(op_i);
    a_zero  = a_i[WIDTH-2:MAN_W] == '0;
    b_zero  = b_i[WIDTH-2:MAN_W] == '0;
    mag_a   = a_zero ? '0 : a_i[WIDTH-2:0];
    mag_b   = b_zero ? '0 : b_i[WIDTH-2:0];
    a_big   = mag_a >= mag_b;
    big     = a_big ? a_i : b_i;
    big_e   = big[WIDTH-2:MAN_W];
    sml_e   = a_big ? (b_zero ? '0 : b_i[WIDTH-2:MAN_W])
                    : (a_zero ? '0 : a_i[WIDTH-2:MAN_W]);
    sml_man = a_big ? b_i[MAN_W-1:0] : a_i[MAN_W-1:0];
    big_sig = (big_e == '0) ? '0 : {1'b1, big[MAN_W-1:0]};
    sml_sig = (sml_e == '0) ? '0 : {1'b1, sml_man};
    diff    = big_e - sml_e;
    sml_sig = sml_sig >> diff;
    sub_n   = a_i[WIDTH-1] != b_i[WIDTH-1];

    // Signed ordering: sign first, then magnitude (reversed when negative).
    a_eq = !sub_n && (mag_a == mag_b);
    if (sub_n)             a_ge = b_i[WIDTH-1];
    else if (a_i[WIDTH-1]) a_ge = mag_a <= mag_b;
    else                   a_ge = mag_a >= mag_b;
    sel_max = a_ge ? a_i : b_i;
    sel_min = (!a_ge || a_eq) ? a_i : b_i;

    byp_n     = 1'b1;
    byp_res_n = '0;
    byp_fl_n  = 2'b00;
    case (op_s)
      OP_ADD: begin
        byp_n     = diff > MAX_SH;
        byp_res_n = big;
      end
      OP_MAX: begin
        byp_res_n = sel_max;
        byp_fl_n  = {1'b0, sel_max[WIDTH-2:MAN_W] == '0};
      end
      OP_MIN: begin
        byp_res_n = sel_min;
        byp_fl_n  = {1'b0, sel_min[WIDTH-2:MAN_W] == '0};
      end
      default: begin
        byp_res_n = '0;
        byp_fl_n  = 2'b00;
      end
    endcase
  end

  logic             byp1, sign1, sub1;
  logic [WIDTH-1:0] byp_res1;
  logic [1:0]       byp_fl1;
  logic [EXP_W-1:0] e1;
  logic [SIG_W-1:0] big_sig1, sml_sig1;

  // S1 register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1 <= 1'b0;
    end else if (adv) begin
      v1       <= valid_i;
      byp1     <= byp_n;
      byp_res1 <= byp_res_n;
      byp_fl1  <= byp_fl_n;
      sign1    <= big[WIDTH-1];
      sub1     <= sub_n;
      e1       <= big_e;
      big_sig1 <= big_sig;
      sml_sig1 <= sml_sig;
    end
  end

  // ---------------- S2: mantissa add/subtract ----------------
  logic             byp2, sign2;
  logic [WIDTH-1:0] byp_res2;
  logic [1:0]       byp_fl2;
  logic [EXP_W-1:0] e2;
  logic [SIG_W:0]   sum2;

  // S2 register; the larger magnitude is always the minuend.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v2 <= 1'b0;
    end else if (adv) begin
      v2       <= v1;
      byp2     <= byp1;
      byp_res2 <= byp_res1;
      byp_fl2  <= byp_fl1;
      sign2    <= sign1;
      e2       <= e1;
      sum2     <= sub1 ? ({1'b0, big_sig1} - {1'b0, sml_sig1})
                       : ({1'b0, big_sig1} + {1'b0, sml_sig1});
    end
  end

  // ---------------- S3: normalise, pack, flags ----------------
  logic [EXP_W+1:0] lz, e_ext, e_n;
  logic [MAN_W-1:0] man_n;
  logic [WIDTH-1:0] res_n;
  logic [1:0]       fl_n;

  // Leading-one detect, renormalise, then classify zero/overflow.
  always_comb begin
    lz = '0;
    for (int unsigned i = 0; i <= MAN_W; i++) begin
      if (sum2[i]) lz = (EXP_W + 2)'(MAN_W - i);
    end
    e_ext = {2'b00, e2};
    if (sum2[SIG_W]) begin
      man_n = sum2[MAN_W:1];
      e_n   = e_ext + (EXP_W + 2)'(1);
    end else begin
      man_n = sum2[MAN_W-1:0] << lz;
      e_n   = e_ext - lz;
    end

    if (byp2) begin
      res_n = byp_res2;
      fl_n  = byp_fl2;
    end else if (sum2 == '0 || e_n[EXP_W+1] || e_n == '0) begin
      res_n = '0;
      fl_n  = 2'b01;
    end else if (e_n >= {2'b00, EXP_MAX}) begin
      res_n = {sign2, EXP_MAX, {MAN_W{1'b0}}};
      fl_n  = 2'b10;
    end else begin
      res_n = {sign2, e_n[EXP_W-1:0], man_n};
      fl_n  = 2'b00;
    end
  end

  // S3 register drives the outputs directly; data only loads behind a valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v3       <= 1'b0;
      result_o <= '0;
      flags_o  <= '0;
    end else if (adv) begin
      v3 <= v2;
      if (v2) begin
        result_o <= res_n;
        flags_o  <= fl_n;
      end
    end
  end

  assign valid_o = v3;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: integer-arithmetic reference model, scoreboard
// queue checked on every output transfer, directed cases and random traffic.
module tb_fp_addsub_pipe;

  localparam int E = 8;
  localparam int M = 15;
  localparam int W = 1 + E + M;

  logic         clk = 1'b0;
  logic         rst_i, valid_i, ready_i, ready_o, valid_o;
  logic [1:0]   op_i, flags_o;
  logic [W-1:0] a_i, b_i, result_o;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(E), .MAN_W(M)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .flags_o(flags_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: returns {flags, result}, computed on plain integers.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
    int ea, eb, eg, es, d, e, cmp;
    longint maga, magb, sg, ss, v;
    logic [W-1:0] big, sml, res;
    ea   = int'(a[W-2:M]);
    eb   = int'(b[W-2:M]);
    maga = (ea == 0) ? 0 : longint'(a[W-2:0]);
    magb = (eb == 0) ? 0 : longint'(b[W-2:0]);
    if (op == 2'b11) return '0;
    if (op != 2'b00) begin
      if (a[W-1] != b[W-1]) cmp = a[W-1] ? -1 : 1;
      else if (maga == magb) cmp = 0;
      else begin
        cmp = (maga > magb) ? 1 : -1;
        if (a[W-1]) cmp = -cmp;
      end
      if (op == 2'b01) res = (cmp >= 0) ? a : b;
      else             res = (cmp <= 0) ? a : b;
      return {1'b0, res[W-2:M] == '0, res};
    end
    big = (maga >= magb) ? a : b;
    sml = (maga >= magb) ? b : a;
    eg  = int'(big[W-2:M]);
    es  = int'(sml[W-2:M]);
    sg  = (eg == 0) ? 0 : (longint'(1) << M) + longint'(big[M-1:0]);
    ss  = (es == 0) ? 0 : (longint'(1) << M) + longint'(sml[M-1:0]);
    d   = eg - es;
    if (d > M + 1) return {2'b00, big};
    ss = ss >> d;
    v  = (a[W-1] == b[W-1]) ? sg + ss : sg - ss;
    if (v == 0) return {2'b01, {W{1'b0}}};
    e = eg;
    while (v >= (longint'(2) << M)) begin v = v / 2; e++; end
    while (v <  (longint'(1) << M)) begin v = v * 2; e--; end
    if (e <= 0) return {2'b01, {W{1'b0}}};
    if (e >= (1 << E) - 1) return {2'b10, big[W-1], {E{1'b1}}, {M{1'b0}}};
    return {2'b00, big[W-1], E'(e), M'(v)};
  endfunction

  typedef struct {
    logic [W-1:0] res;
    logic [1:0]   fl;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  bit           lat_chk = 1'b0;
  bit           saw_stall = 1'b0;
  bit           prev_hold = 1'b0;
  logic [W-1:0] prev_res;
  logic [1:0]   prev_fl;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and protocol checks, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t         ent;
    logic [W+1:0] m;
    if (prev_hold) begin
      check("hold_valid", 64'(valid_o), 64'(1));
      check("hold_result", 64'(result_o), 64'(prev_res));
      check("hold_flags", 64'(flags_o), 64'(prev_fl));
    end
    if (rst_i) begin
      q.delete();
      check("ready_in_reset", 64'(ready_o), 64'(1));
    end else begin
      check("ready_rule", 64'(ready_o), 64'(!valid_o || ready_i));
      if (!ready_o) saw_stall = 1'b1;
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          check("unexpected_output", 64'(result_o), 64'(0));
          check("unexpected_valid", 64'(valid_o), 64'(0));
        end else begin
          ent = q.pop_front();
          check("result", 64'(result_o), 64'(ent.res));
          check("flags", 64'(flags_o), 64'(ent.fl));
          if (lat_chk) check("latency", 64'(cyc - ent.acc + 1), 64'(3));
        end
      end
      if (valid_i && ready_o) begin
        m       = model(a_i, b_i, op_i);
        ent.res = m[W-1:0];
        ent.fl  = m[W+1:W];
        ent.acc = cyc + 1;
        q.push_back(ent);
      end
    end
    prev_hold = !rst_i && valid_o && !ready_i;
    prev_res  = result_o;
    prev_fl   = flags_o;
  end

  // Present one operation starting just after an edge; returns just after
  // the edge that took it.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    int n = 0;
    valid_i = 1'b1;
    a_i = a;
    b_i = b;
    op_i = op;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 64'(ready_o), 64'(1));
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] gen(input int e);
    return {1'($urandom_range(0, 1)), E'(e), M'($urandom)};
  endfunction

  typedef struct {
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic [W+1:0] want;
  } pin_t;

  pin_t pins[10] = '{
    '{24'h3F8000, 24'h3F8000, 2'b00, 26'h0400000},
    '{24'h400000, 24'h3F8000, 2'b00, 26'h0404000},
    '{24'h400000, 24'hBF8000, 2'b00, 26'h03F8000},
    '{24'h3F8000, 24'hBF8000, 2'b00, 26'h1000000},
    '{24'h7F7FFF, 24'h7F7FFF, 2'b00, 26'h27F8000},
    '{24'hC00000, 24'h3F8000, 2'b01, 26'h03F8000},
    '{24'hC00000, 24'h3F8000, 2'b10, 26'h0C00000},
    '{24'h3F8000, 24'h400000, 2'b11, 26'h0000000},
    '{24'h400000, 24'h300000, 2'b00, 26'h0400000},
    '{24'h008001, 24'h808000, 2'b00, 26'h1000000}
  };

  initial begin
    int ea, eb;
    logic [W-1:0] ra, rb;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(valid_o), 64'(0));
    check("rst_result", 64'(result_o), 64'(0));
    check("rst_flags", 64'(flags_o), 64'(0));
    check("rst_ready", 64'(ready_o), 64'(1));

    // Pin the model to hand-computed values, then run the same cases.
    foreach (pins[i]) check($sformatf("model_pin%0d", i),
                            64'(model(pins[i].a, pins[i].b, pins[i].op)), 64'(pins[i].want));
    @(posedge clk);
    #1 lat_chk = 1'b1;
    foreach (pins[i]) send(pins[i].a, pins[i].b, pins[i].op);
    drain();
    lat_chk = 1'b0;

    // Four back-to-back operations with the output stalled for cycles 2-5.
    saw_stall = 1'b0;
    fork
      begin
        send(24'h3F8000, 24'h3F8000, 2'b00);
        send(24'h400000, 24'h3F8000, 2'b00);
        send(24'h400000, 24'hBF8000, 2'b00);
        send(24'hC00000, 24'h3F8000, 2'b10);
      end
      begin
        @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    drain();
    check("burst_saw_stall", 64'(saw_stall), 64'(1));

    // Reset with three operations in flight.
    send(24'h3F8000, 24'h3F8000, 2'b00);
    send(24'h400000, 24'h3F8000, 2'b00);
    send(24'h7F7FFF, 24'h7F7FFF, 2'b00);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(valid_o), 64'(0));
    check("midrst_result", 64'(result_o), 64'(0));
    check("midrst_flags", 64'(flags_o), 64'(0));
    repeat (6) @(posedge clk);
    #1 lat_chk = 1'b1;
    send(24'h400000, 24'hBF8000, 2'b00);
    drain();
    lat_chk = 1'b0;

    // Random traffic with random backpressure and near-equal exponents.
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 3))
        0:       ea = int'($urandom_range(0, 20));
        1:       ea = int'($urandom_range(230, 255));
        default: ea = int'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 4) == 0) eb = int'($urandom_range(0, 255));
      else eb = ea + int'($urandom_range(0, 6)) - 3;
      if (eb < 0) eb = 0;
      if (eb > 255) eb = 255;
      ra = gen(ea);
      rb = gen(eb);
      if ($urandom_range(0, 3) == 0) rb[M-1:0] = ra[M-1:0] ^ M'($urandom_range(0, 3));
      a_i = ra;
      b_i = rb;
      case ($urandom_range(0, 7))
        0:       op_i = 2'b01;
        1:       op_i = 2'b10;
        2:       op_i = 2'b11;
        default: op_i = 2'b00;
      endcase
      valid_i = $urandom_range(0, 3) != 0;
      ready_i = $urandom_range(0, 3) != 0;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
